// File: rtl/assoc_mem_search_if.sv
// assoc_mem_search_if
//   Bundles the query, class-memory and result signals of assoc_mem_search.
//   slave  modport : the search stage itself.
//   master modport : whoever drives queries, serves class reads, takes results.
//   Signals keep the stage's own port names (_i = into the stage, _o = out of it).
//   state_o is a debug view of the search FSM (0 IDLE, 1 SEARCH, 2 DONE).
//   Optional macro AM_THRESHOLD_EN adds dist_thresh_i / no_match_o.
//
//   Handshake rule (both query and result channels): a transfer happens on a
//   rising clk edge where valid and ready are both high; the producer keeps
//   its payload stable while valid is high and ready is low.
interface assoc_mem_search_if #(
  parameter int HVDimension = 512,
  parameter int NumClass    = 32
);
  localparam int ClassAddrWidth = $clog2(NumClass);
  localparam int DistWidth      = $clog2(HVDimension + 1);

  logic [HVDimension-1:0]    qhv_i;
  logic                      qhv_valid_i;
  logic                      qhv_ready_o;
  logic [ClassAddrWidth:0]   num_class_i;
  logic                      class_rd_en_o;
  logic [ClassAddrWidth-1:0] class_rd_addr_o;
  logic [HVDimension-1:0]    class_rd_data_i;
  logic [ClassAddrWidth-1:0] predict_o;
  logic [DistWidth-1:0]      dist_o;
  logic                      predict_valid_o;
  logic                      predict_ready_i;
  logic                      busy_o;
  logic [1:0]                state_o;
`ifdef AM_THRESHOLD_EN
  logic [DistWidth-1:0]      dist_thresh_i;
  logic                      no_match_o;
`endif

  modport slave (
`ifdef AM_THRESHOLD_EN
    input  dist_thresh_i,
    output no_match_o,
`endif
    input  qhv_i, qhv_valid_i, num_class_i, class_rd_data_i, predict_ready_i,
    output qhv_ready_o, class_rd_en_o, class_rd_addr_o, predict_o, dist_o,
    output predict_valid_o, busy_o, state_o
  );

  modport master (
`ifdef AM_THRESHOLD_EN
    output dist_thresh_i,
    input  no_match_o,
`endif
    output qhv_i, qhv_valid_i, num_class_i, class_rd_data_i, predict_ready_i,
    input  qhv_ready_o, class_rd_en_o, class_rd_addr_o, predict_o, dist_o,
    input  predict_valid_o, busy_o, state_o
  );
endinterface

// File: rtl/assoc_mem_search.sv
// assoc_mem_search
//   Associative-memory search: takes one binary query HV, streams class HVs
//   0..N-1 from an external memory (one read per cycle, data one cycle later),
//   and reports the index and Hamming distance of the nearest class.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : assoc_mem_search_if.slave (query in, class reads, result out,
//            busy_o, debug state_o)
// Optional feature (macro AM_THRESHOLD_EN): dist_thresh_i is captured with the
//   query and no_match_o flags a best distance above it while in DONE.
module assoc_mem_search #(
  parameter int HVDimension = 512,
  parameter int NumClass    = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  assoc_mem_search_if.slave bus
);
  localparam int ClassAddrWidth = $clog2(NumClass);
  localparam int DistWidth      = $clog2(HVDimension + 1);
  localparam int CntWidth       = ClassAddrWidth + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} state_e;

  state_e                    state_q, state_d;
  logic [HVDimension-1:0]    qhv_q, qhv_d;
  logic [CntWidth-1:0]       n_q, n_d;
  logic [CntWidth-1:0]       rd_cnt_q, rd_cnt_d;     // reads issued so far
  logic                      rd_en_q, rd_en_d;
  logic [ClassAddrWidth-1:0] rd_addr_q, rd_addr_d;
  logic                      pend_q, pend_d;         // class data arrives this cycle
  logic                      pend_last_q, pend_last_d;
  logic [ClassAddrWidth-1:0] pend_idx_q, pend_idx_d;
  logic [DistWidth-1:0]      min_dist_q, min_dist_d;
  logic [ClassAddrWidth-1:0] min_idx_q, min_idx_d;
  logic [ClassAddrWidth-1:0] predict_q, predict_d;
  logic [DistWidth-1:0]      dist_q, dist_d;
  logic                      valid_q, valid_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
`ifdef AM_THRESHOLD_EN
  logic [DistWidth-1:0]      thresh_q, thresh_d;
  logic                      no_match_q, no_match_d;
`endif

  logic [CntWidth-1:0]       n_eff;
  logic [HVDimension-1:0]    diff;
  logic [DistWidth-1:0]      cur_dist, best_dist;
  logic [ClassAddrWidth-1:0] best_idx;

  // Zero classes still searches class 0; oversize requests clamp to memory size.
  always_comb begin
    if (bus.num_class_i == '0)                          n_eff = CntWidth'(1);
    else if (bus.num_class_i > CntWidth'(NumClass))     n_eff = CntWidth'(NumClass);
    else                                                n_eff = bus.num_class_i;
  end

  always_comb begin
    diff     = qhv_q ^ bus.class_rd_data_i;
    cur_dist = '0;
    for (int i = 0; i < HVDimension; i++) cur_dist = cur_dist + DistWidth'(diff[i]);
  end

  // Strict less-than: on a tie the earlier (lower) index is kept.
  always_comb begin
    best_dist = min_dist_q;
    best_idx  = min_idx_q;
    if (cur_dist < min_dist_q) begin
      best_dist = cur_dist;
      best_idx  = pend_idx_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    qhv_d       = qhv_q;
    n_d         = n_q;
    rd_cnt_d    = rd_cnt_q;
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    pend_d      = pend_q;
    pend_last_d = pend_last_q;
    pend_idx_d  = pend_idx_q;
    min_dist_d  = min_dist_q;
    min_idx_d   = min_idx_q;
    predict_d   = predict_q;
    dist_d      = dist_q;
    valid_d     = valid_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
`ifdef AM_THRESHOLD_EN
    thresh_d    = thresh_q;
    no_match_d  = no_match_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.qhv_valid_i && ready_q) begin
          state_d    = SEARCH;
          qhv_d      = bus.qhv_i;
          n_d        = n_eff;
          rd_en_d    = 1'b1;       // address 0 goes out in the first SEARCH cycle
          rd_addr_d  = '0;
          rd_cnt_d   = CntWidth'(1);
          pend_d     = 1'b0;
          pend_last_d = 1'b0;
          min_dist_d = '1;
          min_idx_d  = '0;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
`ifdef AM_THRESHOLD_EN
          thresh_d   = bus.dist_thresh_i;
`endif
        end
      end
      SEARCH: begin
        // Delay the issued read by one cycle to line up with its data.
        pend_d      = rd_en_q;
        pend_idx_d  = rd_addr_q;
        pend_last_d = rd_en_q && (rd_cnt_q == n_q);
        if (rd_en_q && (rd_cnt_q != n_q)) begin
          rd_addr_d = rd_cnt_q[ClassAddrWidth-1:0];
          rd_cnt_d  = rd_cnt_q + CntWidth'(1);
        end else begin
          rd_en_d   = 1'b0;
        end
        if (pend_q) begin
          min_dist_d = best_dist;
          min_idx_d  = best_idx;
          if (pend_last_q) begin
            state_d   = DONE;
            predict_d = best_idx;
            dist_d    = best_dist;
            valid_d   = 1'b1;
`ifdef AM_THRESHOLD_EN
            no_match_d = (best_dist > thresh_q);
`endif
          end
        end
      end
      DONE: begin
        if (bus.predict_ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
`ifdef AM_THRESHOLD_EN
          no_match_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      qhv_q       <= '0;
      n_q         <= '0;
      rd_cnt_q    <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      pend_idx_q  <= '0;
      min_dist_q  <= '1;
      min_idx_q   <= '0;
      predict_q   <= '0;
      dist_q      <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
`ifdef AM_THRESHOLD_EN
      thresh_q    <= '0;
      no_match_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      qhv_q       <= qhv_d;
      n_q         <= n_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      pend_idx_q  <= pend_idx_d;
      min_dist_q  <= min_dist_d;
      min_idx_q   <= min_idx_d;
      predict_q   <= predict_d;
      dist_q      <= dist_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
`ifdef AM_THRESHOLD_EN
      thresh_q    <= thresh_d;
      no_match_q  <= no_match_d;
`endif
    end
  end

  assign bus.qhv_ready_o     = ready_q;
  assign bus.class_rd_en_o   = rd_en_q;
  assign bus.class_rd_addr_o = rd_addr_q;
  assign bus.predict_o       = predict_q;
  assign bus.dist_o          = dist_q;
  assign bus.predict_valid_o = valid_q;
  assign bus.busy_o          = busy_q;
  assign bus.state_o         = state_q;
`ifdef AM_THRESHOLD_EN
  assign bus.no_match_o      = no_match_q;
`endif
endmodule

// File: tb/tb_assoc_mem_search.sv
// tb_assoc_mem_search
//   Bench for assoc_mem_search: behavioural class memory, a reference model
//   that pushes {index, distance} per query into exp_q, and scenario tasks.
//   Build with +define+AM_THRESHOLD_EN to include the threshold scenario.
module tb_assoc_mem_search;
  localparam int H  = 512;
  localparam int NC = 32;
  localparam int AW = $clog2(NC);
  localparam int DW = $clog2(H + 1);
  localparam int CW = AW + 1;

  logic clk_i;
  logic rst_ni;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [H-1:0]     mem [NC];
  logic [AW-1:0]    rd_log[$];
  logic [AW+DW-1:0] exp_q[$];

  assoc_mem_search_if #(.HVDimension(H), .NumClass(NC)) bus();

  assoc_mem_search #(.HVDimension(H), .NumClass(NC)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Class memory: data for an accepted read is presented the following cycle.
  always @(posedge clk_i) begin
    if (bus.class_rd_en_o) begin
      bus.class_rd_data_i <= mem[bus.class_rd_addr_o];
      rd_log.push_back(bus.class_rd_addr_o);
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [H-1:0] rand_hv();
    logic [H-1:0] v;
    for (int i = 0; i < H / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [H-1:0] mask_bits(input int cnt, input int off);
    logic [H-1:0] m;
    m = '0;
    for (int i = 0; i < cnt; i++) m[(off + i) % H] = 1'b1;
    return m;
  endfunction

  task automatic model_push(input logic [H-1:0] q, input int n);
    int ne, bd, bi, d;
    ne = (n == 0) ? 1 : ((n > NC) ? NC : n);
    bd = H + 1;
    bi = 0;
    for (int k = 0; k < ne; k++) begin
      d = $countones(q ^ mem[k]);
      if (d < bd) begin bd = d; bi = k; end
    end
    exp_q.push_back({AW'(bi), DW'(bd)});
  endtask

  // Returns at the falling edge just after the handshake edge.
  task automatic send_query(input logic [H-1:0] q, input int n, input bit do_push);
    int guard;
    guard = 0;
    @(negedge clk_i);
    while (!bus.qhv_ready_o && guard < 200) begin @(negedge clk_i); guard++; end
    bus.qhv_i       = q;
    bus.num_class_i = CW'(n);
    bus.qhv_valid_i = 1'b1;
    if (do_push) model_push(q, n);
    @(posedge clk_i);
    @(negedge clk_i);
    bus.qhv_valid_i = 1'b0;
  endtask

  // exp_lat counts falling edges after send_query returns; a query of N classes
  // gives N+1 (the result cycle starts N+2 cycles after the handshake cycle).
  task automatic collect_result(input int exp_lat, input string tag);
    int lat;
    logic [AW+DW-1:0] e;
    lat = 0;
    while (!bus.predict_valid_o && lat < 200) begin @(negedge clk_i); lat++; end
    n_checks++;
    if (!bus.predict_valid_o) begin
      n_fail++;
      $display("FAIL %s_timeout: predict_valid_o=0 after %0d cycles, required 1", tag, lat);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_lat >= 0) begin
      n_checks++;
      if (lat !== exp_lat) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d, required %0d", tag, lat, exp_lat);
      end
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard: result with empty expected queue, required an entry", tag);
    end else begin
      e = exp_q.pop_front();
      if (bus.predict_o !== e[DW +: AW]) begin
        n_fail++;
        $display("FAIL %s_predict: got %0d, required %0d", tag, bus.predict_o, e[DW +: AW]);
      end
      n_checks++;
      if (bus.dist_o !== e[DW-1:0]) begin
        n_fail++;
        $display("FAIL %s_dist: got %0d, required %0d", tag, bus.dist_o, e[DW-1:0]);
      end
    end
    bus.predict_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.predict_ready_i = 1'b0;
    n_checks++;
    if (bus.predict_valid_o !== 1'b0 || bus.qhv_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_release: valid=%b ready=%b busy=%b, required 0 1 0", tag,
               bus.predict_valid_o, bus.qhv_ready_o, bus.busy_o);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_checks++;
    if (bus.qhv_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_qhv_ready: got %b, required 1", bus.qhv_ready_o); end
    n_checks++;
    if (bus.predict_valid_o !== 1'b0 || bus.class_rd_en_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: valid=%b rd_en=%b busy=%b, required 0 0 0",
               bus.predict_valid_o, bus.class_rd_en_o, bus.busy_o);
    end
    n_checks++;
    if (bus.predict_o !== '0 || bus.dist_o !== '0 || bus.class_rd_addr_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data: predict=%0d dist=%0d addr=%0d, required 0 0 0",
               bus.predict_o, bus.dist_o, bus.class_rd_addr_o);
    end
    n_checks++;
    if (bus.state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, required 0", bus.state_o); end
  endtask

  task automatic test_basic();
    logic [H-1:0] q;
    q = rand_hv();
    mem[0] = '0;
    mem[1] = '1;
    mem[2] = q;
    mem[3] = q ^ mask_bits(10, 100);
    rd_log.delete();
    send_query(q, 4, 1'b1);
    n_checks++;
    if (bus.busy_o !== 1'b1 || bus.qhv_ready_o !== 1'b0 || bus.class_rd_en_o !== 1'b1 || bus.class_rd_addr_o !== '0) begin
      n_fail++;
      $display("FAIL basic_search_start: busy=%b ready=%b rd_en=%b addr=%0d, required 1 0 1 0",
               bus.busy_o, bus.qhv_ready_o, bus.class_rd_en_o, bus.class_rd_addr_o);
    end
    collect_result(5, "basic");
    n_checks++;
    if (rd_log.size() != 4 || rd_log[0] !== 5'd0 || rd_log[1] !== 5'd1 || rd_log[2] !== 5'd2 || rd_log[3] !== 5'd3) begin
      n_fail++;
      $display("FAIL basic_reads: got %0d reads, required addresses 0..3", rd_log.size());
    end
  endtask

  task automatic test_tie();
    logic [H-1:0] q;
    q = rand_hv();
    mem[0] = q ^ mask_bits(20, 0);
    mem[1] = q ^ mask_bits(7, 40);
    mem[2] = q ^ mask_bits(9, 80);
    mem[3] = q ^ mask_bits(7, 300);
    send_query(q, 4, 1'b1);
    collect_result(5, "tie");
  endtask

  task automatic test_backpressure();
    logic [H-1:0] q, q2;
    logic [AW+DW-1:0] e;
    int lat;
    q  = rand_hv();
    q2 = rand_hv();
    for (int k = 0; k < 4; k++) mem[k] = rand_hv();
    mem[1] = q ^ mask_bits(33, 17);
    send_query(q, 4, 1'b1);
    lat = 0;
    while (!bus.predict_valid_o && lat < 200) begin @(negedge clk_i); lat++; end
    e = exp_q.pop_front();
    // Offer a second query during the stall; it must wait.
    bus.qhv_i = q2;
    bus.num_class_i = CW'(4);
    bus.qhv_valid_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (bus.predict_valid_o !== 1'b1 || bus.predict_o !== e[DW +: AW] || bus.dist_o !== e[DW-1:0] ||
          bus.qhv_ready_o !== 1'b0 || bus.state_o !== 2'd2) begin
        n_fail++;
        $display("FAIL bp_hold_c%0d: valid=%b predict=%0d dist=%0d ready=%b state=%0d, required 1 %0d %0d 0 2",
                 c, bus.predict_valid_o, bus.predict_o, bus.dist_o, bus.qhv_ready_o, bus.state_o,
                 e[DW +: AW], e[DW-1:0]);
      end
      @(negedge clk_i);
    end
    bus.predict_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.predict_ready_i = 1'b0;
    n_checks++;
    if (bus.predict_valid_o !== 1'b0 || bus.qhv_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b ready=%b busy=%b, required 0 1 0",
               bus.predict_valid_o, bus.qhv_ready_o, bus.busy_o);
    end
    model_push(q2, 4);
    @(posedge clk_i);
    @(negedge clk_i);
    bus.qhv_valid_i = 1'b0;
    n_checks++;
    if (bus.busy_o !== 1'b1 || bus.qhv_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_second_accept: busy=%b ready=%b, required 1 0", bus.busy_o, bus.qhv_ready_o);
    end
    collect_result(5, "bp_second");
  endtask

  task automatic test_bounds();
    logic [H-1:0] q;
    bit order_ok;
    q = rand_hv();
    for (int k = 0; k < NC; k++) mem[k] = q ^ mask_bits(20 + k, k * 3);
    mem[27] = q ^ mask_bits(4, 200);
    rd_log.delete();
    send_query(q, 0, 1'b1);
    collect_result(2, "bound_zero");
    n_checks++;
    if (rd_log.size() != 1 || rd_log[0] !== '0) begin
      n_fail++;
      $display("FAIL bound_zero_reads: got %0d reads, required 1 at addr 0", rd_log.size());
    end
    rd_log.delete();
    send_query(q, 40, 1'b1);
    collect_result(NC + 1, "bound_clamp");
    order_ok = (rd_log.size() == NC);
    for (int k = 0; k < rd_log.size() && k < NC; k++) if (rd_log[k] !== AW'(k)) order_ok = 1'b0;
    n_checks++;
    if (!order_ok) begin
      n_fail++;
      $display("FAIL bound_clamp_reads: got %0d reads, required addresses 0..%0d in order", rd_log.size(), NC - 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [H-1:0] q;
    q = rand_hv();
    for (int k = 0; k < 8; k++) mem[k] = rand_hv();
    send_query(q, 8, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if (bus.class_rd_en_o !== 1'b1 || bus.class_rd_addr_o !== 5'd2) begin
      n_fail++;
      $display("FAIL rst_mid_third_read: rd_en=%b addr=%0d, required 1 2", bus.class_rd_en_o, bus.class_rd_addr_o);
    end
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (bus.predict_valid_o !== 1'b0 || bus.class_rd_en_o !== 1'b0 || bus.busy_o !== 1'b0 ||
        bus.class_rd_addr_o !== '0 || bus.state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_mid_abort: valid=%b rd_en=%b busy=%b addr=%0d state=%0d, required 0 0 0 0 0",
               bus.predict_valid_o, bus.class_rd_en_o, bus.busy_o, bus.class_rd_addr_o, bus.state_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (bus.qhv_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_release: ready=%b busy=%b, required 1 0", bus.qhv_ready_o, bus.busy_o);
    end
    q = rand_hv();
    mem[5] = q ^ mask_bits(2, 9);
    send_query(q, 8, 1'b1);
    collect_result(9, "rst_mid_next");
  endtask

  task automatic test_back_to_back();
    int sent, got, cyc, last_hs;
    logic [H-1:0] q;
    logic [AW+DW-1:0] e;
    sent = 0; got = 0; cyc = 0; last_hs = 0;
    for (int k = 0; k < 4; k++) mem[k] = rand_hv();
    bus.predict_ready_i = 1'b1;
    while (got < 3 && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      if (bus.predict_valid_o) begin
        n_checks++;
        e = exp_q.pop_front();
        if (bus.predict_o !== e[DW +: AW] || bus.dist_o !== e[DW-1:0]) begin
          n_fail++;
          $display("FAIL b2b_result%0d: predict=%0d dist=%0d, required %0d %0d", got,
                   bus.predict_o, bus.dist_o, e[DW +: AW], e[DW-1:0]);
        end
        got++;
      end
      if (bus.qhv_ready_o && sent < 3) begin
        if (sent > 0) begin
          n_checks++;
          if (cyc - last_hs != 7) begin
            n_fail++;
            $display("FAIL b2b_period%0d: got %0d cycles, required 7", sent, cyc - last_hs);
          end
        end
        q = rand_hv();
        bus.qhv_i = q;
        bus.num_class_i = CW'(4);
        bus.qhv_valid_i = 1'b1;
        model_push(q, 4);
        last_hs = cyc;
        sent++;
      end else begin
        bus.qhv_valid_i = 1'b0;
      end
    end
    bus.qhv_valid_i = 1'b0;
    bus.predict_ready_i = 1'b0;
    n_checks++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, required 3", got);
    end
    @(negedge clk_i);
  endtask

`ifdef AM_THRESHOLD_EN
  task automatic test_threshold();
    logic [H-1:0] q;
    int lat;
    bus.dist_thresh_i = DW'(5);
    for (int pass = 0; pass < 2; pass++) begin
      q = rand_hv();
      mem[0] = q ^ mask_bits(pass == 0 ? 6 : 5, 50);
      mem[1] = q ^ mask_bits(9, 400);
      send_query(q, 2, 1'b1);
      n_checks++;
      if (bus.no_match_o !== 1'b0) begin n_fail++; $display("FAIL thr_search%0d: no_match=%b, required 0", pass, bus.no_match_o); end
      lat = 0;
      while (!bus.predict_valid_o && lat < 200) begin @(negedge clk_i); lat++; end
      n_checks++;
      if (bus.no_match_o !== (pass == 0)) begin
        n_fail++;
        $display("FAIL thr_flag%0d: no_match=%b, required %0d", pass, bus.no_match_o, pass == 0);
      end
      collect_result(0, "thr");
      n_checks++;
      if (bus.no_match_o !== 1'b0) begin n_fail++; $display("FAIL thr_idle%0d: no_match=%b, required 0", pass, bus.no_match_o); end
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    rst_ni              = 1'b0;
    bus.qhv_i           = '0;
    bus.qhv_valid_i     = 1'b0;
    bus.num_class_i     = '0;
    bus.predict_ready_i = 1'b0;
    bus.class_rd_data_i = '0;
`ifdef AM_THRESHOLD_EN
    bus.dist_thresh_i   = '0;
`endif
    for (int k = 0; k < NC; k++) mem[k] = '0;
    repeat (3) @(negedge clk_i);
    test_reset();
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (bus.qhv_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b, required 1", bus.qhv_ready_o); end
    test_basic();
    test_tie();
    test_backpressure();
    test_bounds();
    test_reset_mid();
    test_back_to_back();
`ifdef AM_THRESHOLD_EN
    test_threshold();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
